activation_stream: RTL and testbench

Streaming, multi-mode activation unit that replaces the single-cycle, full-width activation register stage at the systolic array output. It accepts a row of SA_LENGTH accumulator results as SA_LENGTH/LANES beats of LANES elements over a valid/ready handshake. It applies the mode latched at job start, with hard-sigmoid, hard-tanh and leaky-ReLU modes added. It emits the results with back-pressure support and a last/done indication toward the output buffer.

---
 rtl/activation_pkg.sv | 29 ++
 rtl/activation_lane.sv | 47 ++++
 rtl/activation_stream.sv | 140 ++++++++++++++
 tb/tb_activation_stream.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/activation_pkg.sv
// Shared types and fixed-point helpers for the streaming activation unit.
package activation_pkg;

  typedef enum logic [2:0] {
    RELU    = 3'd0,
    SIGMOID = 3'd1,
    TANH    = 3'd2,
    IDENT   = 3'd3,
    LEAKY   = 3'd4
  } mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_S = 7;

  // ONE in S-fractional-bit fixed point; also the saturation bound for sigmoid/tanh.
  function automatic int one_val(input int s);
    return 1 << s;
  endfunction

  function automatic int half_val(input int s);
    return (1 << s) >> 1;
  endfunction

endpackage

// File: rtl/activation_lane.sv
// Combinational activation function for one signed fixed-point element.
module activation_lane
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int S          = DEF_S,
  parameter int LEAK_SHIFT = 3
) (
  input  logic [2:0]                   mode_i,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  output logic        [DATA_WIDTH-1:0] y_o
);

  localparam int W = DATA_WIDTH + 2;
  localparam logic signed [W-1:0] ONE_W     = W'(one_val(S));
  localparam logic signed [W-1:0] NEG_ONE_W = -ONE_W;
  localparam logic signed [W-1:0] HALF_W    = W'(half_val(S));
  localparam logic [DATA_WIDTH-1:0] ONE_D     = DATA_WIDTH'(one_val(S));
  localparam logic [DATA_WIDTH-1:0] NEG_ONE_D = DATA_WIDTH'(-one_val(S));

  logic signed [W-1:0] x_w;
  logic signed [W-1:0] sig_w;

  assign x_w   = {{2{x_i[DATA_WIDTH-1]}}, x_i};
  assign sig_w = (x_w >>> 2) + HALF_W;

  // NOTE: y_o gets a value on every path (default arm included), so no latch is inferred.
  always_comb begin
    unique case (mode_i)
      RELU:    y_o = x_w[W-1] ? '0 : x_i;
      SIGMOID: begin
        if (sig_w[W-1])         y_o = '0;
        else if (sig_w > ONE_W) y_o = ONE_D;
        else                    y_o = DATA_WIDTH'(sig_w);
      end
      TANH: begin
        if (x_w > ONE_W)          y_o = ONE_D;
        else if (x_w < NEG_ONE_W) y_o = NEG_ONE_D;
        else                      y_o = x_i;
      end
      IDENT:   y_o = x_i;
      LEAKY:   y_o = x_w[W-1] ? DATA_WIDTH'(x_w >>> LEAK_SHIFT) : x_i;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/activation_stream.sv
// Streaming activation stage: beat-serial row input, one output register with
// valid/ready back-pressure, last/done framing toward the output buffer.
module activation_stream
  import activation_pkg::*;
#(
  parameter int DATA_WIDTH = 11,
  parameter int SA_LENGTH  = 256,
  parameter int LANES      = 16,
  parameter int S          = DEF_S,
  parameter int LEAK_SHIFT = 3
) (
  input  logic                             clk,
  input  logic                             async_rst,
  input  logic                             sync_rst,
  input  logic                             start,
  input  logic [2:0]                       mode,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0][DATA_WIDTH-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [LANES-1:0][DATA_WIDTH-1:0] out_data,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done
);

  localparam int BEATS = SA_LENGTH / LANES;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  if (SA_LENGTH % LANES != 0) begin : g_bad_cfg
    $error("activation_stream: SA_LENGTH must be a multiple of LANES");
  end

  state_t                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [2:0]                         mode_q, mode_d;
  logic                               out_valid_q, out_valid_d;
  logic                               out_last_q, out_last_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]   out_data_q, out_data_d;
  logic                               done_q, done_d;
  logic [LANES-1:0][DATA_WIDTH-1:0]   lane_y;
  logic                               in_accept, out_accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    activation_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .S          (S),
      .LEAK_SHIFT (LEAK_SHIFT)
    ) u_lane (
      .mode_i (mode_q),
      .x_i    (in_data[i]),
      .y_o    (lane_y[i])
    );
  end

  // The single output slot may be refilled in the same cycle it drains.
  assign in_ready   = (state_q == RUN) && (!out_valid_q || out_ready);
  assign in_accept  = in_valid && in_ready;
  assign out_accept = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    done_d      = 1'b0;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (in_accept) begin
          if (cnt_q == LAST_BEAT) state_d = DRAIN;
          else                    cnt_d   = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        if (out_accept) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (in_accept) begin
      out_data_d  = lane_y;
      out_valid_d = 1'b1;
      out_last_d  = (cnt_q == LAST_BEAT);
    end else if (out_accept) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else if (sync_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      done_q      <= done_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign done      = done_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);

endmodule

// File: tb/tb_activation_stream.sv
// Randomized self-checking bench for activation_stream against an arithmetic reference model.
module tb_activation_stream;

  localparam int DW    = 11;
  localparam int SA    = 256;
  localparam int LN    = 16;
  localparam int BEATS = SA / LN;
  localparam int LN1   = 256;
  localparam int ONE   = 128;
  localparam int MAXC  = 4000;

  logic clk = 1'b0;
  logic async_rst, sync_rst;
  always #5 clk = ~clk;

  logic                   start, in_valid, in_ready, out_valid, out_ready, out_last, busy, done;
  logic [2:0]             mode;
  logic [LN-1:0][DW-1:0]  in_data, out_data;

  logic                   b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic                   b_out_last, b_busy, b_done;
  logic [2:0]             b_mode;
  logic [LN1-1:0][DW-1:0] b_in_data, b_out_data;

  activation_stream #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .LANES(LN), .S(7), .LEAK_SHIFT(3)) dut (
    .clk(clk), .async_rst(async_rst), .sync_rst(sync_rst), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  activation_stream #(.DATA_WIDTH(DW), .SA_LENGTH(SA), .LANES(LN1), .S(7), .LEAK_SHIFT(3)) dut1 (
    .clk(clk), .async_rst(async_rst), .sync_rst(sync_rst), .start(b_start), .mode(b_mode),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_last(b_out_last), .busy(b_busy), .done(b_done)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int v[LN];
    bit last;
  } beat_t;

  beat_t sb[$];
  int    dir[$];

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic int rnd_val();
    return int'($urandom_range(2047)) - 1024;
  endfunction

  function automatic int floor_shr(input int x, input int k);
    int d;
    d = 1 << k;
    return (x >= 0) ? x / d : -((-x + d - 1) / d);
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  function automatic int ref_f(input int m, input int x);
    case (m)
      0:       return (x < 0) ? 0 : x;
      1:       return clampi(floor_shr(x, 2) + ONE / 2, 0, ONE);
      2:       return clampi(x, -ONE, ONE);
      3:       return x;
      4:       return (x < 0) ? floor_shr(x, 3) : x;
      default: return 0;
    endcase
  endfunction

  task automatic cmp_beat(input string tag, input beat_t e);
    int bad;
    logic signed [DW-1:0] g;
    bad = -1;
    for (int l = 0; l < LN; l++) begin
      g = out_data[l];
      if (bad < 0 && int'(g) != e.v[l]) bad = l;
    end
    if (bad < 0) bad = 0;
    g = out_data[bad];
    check(tag, g, e.v[bad]);
  endtask

  task automatic run_job(input int m, input int stall_pct);
    int    src[BEATS][LN];
    int    sent, got, cyc;
    bit    exp_ready;
    beat_t e;
    sent = 0; got = 0; cyc = 0;
    for (int b = 0; b < BEATS; b++)
      for (int l = 0; l < LN; l++)
        src[b][l] = (l < dir.size()) ? dir[l] : rnd_val();
    sb.delete();
    @(negedge clk);
    start = 1'b1; mode = 3'(m);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    while (got < BEATS && cyc < MAXC) begin
      out_ready = ($urandom_range(99) >= stall_pct);
      in_valid  = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) < 75);
      for (int l = 0; l < LN; l++)
        in_data[l] = DW'((sent < BEATS) ? src[sent][l] : rnd_val());
      mode  = 3'($urandom_range(7));
      start = ($urandom_range(9) == 0);
      #1;
      exp_ready = (sent < BEATS) && (sb.size() == 0 || out_ready);
      check("in_ready", in_ready, exp_ready);
      check("out_valid", out_valid, sb.size() > 0);
      check("done_in_job", done, 0);
      if (sb.size() > 0) begin
        cmp_beat("out_data", sb[0]);
        check("out_last", out_last, sb[0].last);
        if (out_ready) begin
          void'(sb.pop_front());
          got++;
        end
      end
      if (in_valid && exp_ready) begin
        for (int l = 0; l < LN; l++) e.v[l] = ref_f(m, src[sent][l]);
        e.last = (sent == BEATS - 1);
        sb.push_back(e);
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (cyc >= MAXC) check("job_timeout", 0, 1);
    if (stall_pct == 0) check("job_cycles", cyc, BEATS + 1);
    #1;
    check("done_pulse", done, 1);
    check("busy_after_done", busy, 0);
    @(negedge clk);
    check("done_clear", done, 0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data_nz"}, |out_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  task automatic reset_mid_job(input bit use_async);
    @(negedge clk);
    start = 1'b1; mode = 3'd0;
    @(negedge clk);
    start = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    repeat (7) begin
      for (int l = 0; l < LN; l++) in_data[l] = DW'(rnd_val());
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    check("pre_reset_valid", out_valid, 1);
    if (use_async) begin
      #1 async_rst = 1'b0;
      #1 check_cleared("arst");
      @(negedge clk);
      async_rst = 1'b1;
    end else begin
      sync_rst = 1'b1;
      @(negedge clk);
      sync_rst = 1'b0;
      #1 check_cleared("srst");
    end
    repeat (3) begin
      @(negedge clk);
      check("no_done_after_reset", done, 0);
    end
  endtask

  task automatic run_single_beat(input int m);
    int exp_v[LN1];
    int bad;
    logic signed [DW-1:0] g;
    @(negedge clk);
    b_start = 1'b1; b_mode = 3'(m);
    @(negedge clk);
    b_start = 1'b0; b_out_ready = 1'b0; b_in_valid = 1'b1;
    for (int l = 0; l < LN1; l++) begin
      exp_v[l]     = rnd_val();
      b_in_data[l] = DW'(exp_v[l]);
      exp_v[l]     = ref_f(m, exp_v[l]);
    end
    b_mode = 3'($urandom_range(7));
    #1 check("b_in_ready", b_in_ready, 1);
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    check("b_out_valid", b_out_valid, 1);
    check("b_out_last", b_out_last, 1);
    check("b_in_ready_drain", b_in_ready, 0);
    bad = -1;
    for (int l = 0; l < LN1; l++) begin
      g = b_out_data[l];
      if (bad < 0 && int'(g) != exp_v[l]) bad = l;
    end
    if (bad < 0) bad = 0;
    g = b_out_data[bad];
    check("b_out_data", g, exp_v[bad]);
    b_out_ready = 1'b1;
    @(negedge clk);
    b_out_ready = 1'b0;
    #1;
    check("b_done", b_done, 1);
    check("b_busy", b_busy, 0);
    @(negedge clk);
    check("b_done_clear", b_done, 0);
  endtask

  initial begin
    async_rst = 1'b0; sync_rst = 1'b0;
    start = 1'b0; mode = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_start = 1'b0; b_mode = '0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    check("reset_b_busy", b_busy, 0);
    check("reset_b_out_valid", b_out_valid, 0);
    async_rst = 1'b1;

    dir = '{-5, 0, 300, -1024};  run_job(0, 0);
    dir = '{0, 128, 400, -300};  run_job(1, 30);
    dir = '{200, -50, -1024};    run_job(2, 50);
    dir.delete();                run_job(3, 50);
    dir = '{-40, -41, 17};       run_job(4, 50);
    dir.delete();                run_job(6, 20);
    reset_mid_job(1'b1);
    dir.delete();                run_job(0, 50);
    reset_mid_job(1'b0);
    dir = '{-1, -8, -9, 1023};   run_job(4, 0);
    run_single_beat(0);
    run_single_beat(1);
    run_single_beat(2);
    run_single_beat(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
